gmux_enable_sequencer: RTL and testbench
========================================

Name: gmux_enable_sequencer

Overview:
- Sequences the select (IS0) lines of a bank of global clock muxes, so each global clock buffer is enabled or disabled one at a time.
- Requesters present a desired enable vector. The block applies one select change at a time, waits a fixed settle window, then acknowledges.
- Purpose: limit simultaneous clock-network switching and give downstream logic a defined point where each clock is stable.
- Sits between fabric configuration/power-management logic and the GMUX IS0 inputs.

Parameters:
- NUM_GMUX, 5, number of GMUX select lines controlled (>=1).
- SETTLE_CYCLES, 4, cycles held after a select change before acknowledge (>=1).
- IDX_W, $clog2(NUM_GMUX) (min 1), width of the channel index.
- CNT_W, $clog2(SETTLE_CYCLES+1), width of the settle counter.

Ports:
- CLK  input  1  sequencer clock; free-running, not derived from any controlled GMUX.
- RST_N  input  1  reset; one clock; asynchronous assert, active-low.
- REQ_EN  input  NUM_GMUX  desired select state per GMUX; level, synchronous to CLK.
- IS0  output  NUM_GMUX  registered select drive to the GMUX IS0 pins.
- ACK  output  NUM_GMUX  one-cycle pulse; IS0[i] has settled at its new value.
- BUSY  output  1  high while a change is in flight (SETTLE or DONE).
- CUR_IDX  output  IDX_W  channel currently being changed; holds last value when idle.

Behaviour:
- Reset (RST_N low, asynchronous):
  - IS0=0, ACK=0, BUSY=0, CUR_IDX=0, round-robin pointer=0, counter=0, state=IDLE.
  - Reset mid-sequence abandons the change; no ACK is issued.
- All state updates on rising CLK. All outputs are registered.
- Pending vector: MISMATCH = REQ_EN ^ IS0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - If MISMATCH==0, stay in IDLE.
  - Else choose idx = first set bit of MISMATCH searching upward from the pointer, wrapping from NUM_GMUX-1 to 0.
  - On that edge: IS0[idx] <= ~IS0[idx], CUR_IDX <= idx, counter <= SETTLE_CYCLES-1, BUSY <= 1, go to SETTLE.
- SETTLE:
  - Each edge: if counter==0 go to DONE and set ACK[CUR_IDX] <= 1; else decrement the counter.
  - IS0 is frozen; REQ_EN is ignored.
- DONE:
  - One cycle only. On the next edge: ACK <= 0, BUSY <= 0, pointer <= CUR_IDX+1 (wraps to 0 past NUM_GMUX-1), go to IDLE.
- Timing:
  - IS0 changes at edge E.
  - ACK is high for exactly the one cycle between edges E+SETTLE_CYCLES and E+SETTLE_CYCLES+1.
  - BUSY is high from edge E to edge E+SETTLE_CYCLES+1.
  - The earliest next IS0 change is edge E+SETTLE_CYCLES+2.
- At most one IS0 bit changes per sequence; at most one ACK bit is ever high.
- Request reversal mid-sequence: the in-flight change still completes and is ACKed. The resulting mismatch is then serviced as a new sequence that restores the bit.
- Multiple simultaneous requests are serviced in round-robin order from the pointer; no channel starves.
- Requests that match IS0 (no-ops) never start a sequence.
- SETTLE_CYCLES=1: the first SETTLE edge moves to DONE.

Test Plan:
- Reset: hold RST_N=0 with REQ_EN=5'b11111, release -> IS0=0, ACK=0, BUSY=0 at release; first IS0 change is IS0[0] on the first edge after release.
- Single enable: REQ_EN=5'b00100 from IDLE at edge E -> IS0=5'b00100 after E, CUR_IDX=2, BUSY=1; ACK=5'b00100 for one cycle after E+4; BUSY=0 after E+5.
- Round-robin: pointer=3, REQ_EN=5'b01011 from IS0=0 -> IS0 bits set in order 3, 0, 1; sequences spaced 6 cycles apart; ACK order 3, 0, 1.
- Reversal: raise REQ_EN[1], drop it 2 cycles later -> IS0[1] rises, ACK[1] pulses, then IS0[1] falls 2 cycles after that ACK with a second ACK[1].
- Async reset mid-SETTLE: assert RST_N=0 between edges (not at an edge) -> IS0, BUSY and ACK go to 0 immediately, before the next CLK edge; no ACK is produced for the abandoned change.
- SETTLE_CYCLES=1 build: single request -> ACK high in the cycle after the IS0 change; BUSY high for 2 cycles.

Source files
------------

// File: rtl/gmux_enable_sequencer.sv
// gmux_enable_sequencer
//   Drives the IS0 select lines of a bank of global clock muxes so that only
//   one select changes at a time. After each change the block waits a fixed
//   settle window, then pulses ACK for the channel that changed. Pending
//   changes are picked round-robin so no channel can starve.
//
// Ports
//   CLK      free-running sequencer clock (not derived from any GMUX)
//   RST_N    asynchronous active-low reset
//   REQ_EN   desired select state per GMUX (level, synchronous to CLK)
//   IS0      registered select drive to the GMUX IS0 pins
//   ACK      one-cycle pulse: IS0[i] has settled at its new value
//   BUSY     high while a change is in flight (SETTLE or DONE)
//   CUR_IDX  channel currently being changed; holds last value when idle
module gmux_enable_sequencer #(
    parameter int NUM_GMUX      = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int IDX_W         = (NUM_GMUX > 1) ? $clog2(NUM_GMUX) : 1,
    parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_GMUX-1:0] REQ_EN,
    output logic [NUM_GMUX-1:0] IS0,
    output logic [NUM_GMUX-1:0] ACK,
    output logic                BUSY,
    output logic [IDX_W-1:0]    CUR_IDX
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int unsigned N = NUM_GMUX;

    logic [1:0]          state;
    logic [IDX_W-1:0]    ptr;
    logic [CNT_W-1:0]    cnt;

    logic [NUM_GMUX-1:0] pending;
    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    probe;
    int unsigned         j;

    // Round-robin pick: first pending channel at or above the pointer,
    // wrapping from the top channel back to channel 0.
    always_comb begin
        pending = REQ_EN ^ IS0;
        found   = 1'b0;
        pick    = '0;
        probe   = '0;
        j       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            probe = IDX_W'(j);
            if (!found && pending[probe]) begin
                found = 1'b1;
                pick  = probe;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            IS0     <= '0;
            ACK     <= '0;
            BUSY    <= 1'b0;
            CUR_IDX <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        IS0[pick] <= ~IS0[pick];
                        CUR_IDX   <= pick;
                        cnt       <= CNT_W'(SETTLE_CYCLES - 1);
                        BUSY      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // IS0 is frozen and REQ_EN ignored until the window ends.
                    if (cnt == '0) begin
                        ACK[CUR_IDX] <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    ACK  <= '0;
                    BUSY <= 1'b0;
                    if (CUR_IDX == IDX_W'(NUM_GMUX - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= CUR_IDX + 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmux_enable_sequencer.sv
// Testbench for gmux_enable_sequencer: a default build (SETTLE_CYCLES=4) and
// a SETTLE_CYCLES=1 build. Expected ACK events are queued when requests are
// driven and popped by a monitor whenever a DUT raises ACK.
module tb_gmux_enable_sequencer;

    logic       CLK;
    logic       RST_N;
    logic [4:0] req_a, is0_a, ack_a;
    logic       busy_a;
    logic [2:0] cur_a;
    logic [4:0] req_b, is0_b, ack_b;
    logic       busy_b;
    logic [2:0] cur_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0] ack;
        logic [4:0] is0;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    gmux_enable_sequencer #(.NUM_GMUX(5), .SETTLE_CYCLES(4)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .REQ_EN(req_a), .IS0(is0_a),
        .ACK(ack_a), .BUSY(busy_a), .CUR_IDX(cur_a)
    );

    gmux_enable_sequencer #(.NUM_GMUX(5), .SETTLE_CYCLES(1)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .REQ_EN(req_b), .IS0(is0_b),
        .ACK(ack_b), .BUSY(busy_b), .CUR_IDX(cur_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitors: every ACK pulse must match the next queued event.
    always @(negedge CLK) begin
        if (ack_a !== 5'b0) begin
            if (qa.size() == 0) begin
                check("a_ack_unexpected", 32'(ack_a), 32'h0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_ack_sb", 32'(ack_a), 32'(e.ack));
                check("a_ack_is0_sb", 32'(is0_a), 32'(e.is0));
            end
        end
        if (ack_b !== 5'b0) begin
            if (qb.size() == 0) begin
                check("b_ack_unexpected", 32'(ack_b), 32'h0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_ack_sb", 32'(ack_b), 32'(e.ack));
                check("b_ack_is0_sb", 32'(is0_b), 32'(e.is0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full SETTLE_CYCLES=4 sequence on dut_a, starting with the change
    // at the next edge E; returns just after edge E+5 (back in IDLE).
    task automatic run_seq_a(input int idx, input logic [4:0] is0_after);
        logic [4:0] oh;
        exp_t e;
        oh    = 5'b00001 << idx;
        e.ack = oh;
        e.is0 = is0_after;
        qa.push_back(e);
        tick();
        check("a_is0_change", 32'(is0_a), 32'(is0_after));
        check("a_cur_idx", 32'(cur_a), 32'(idx));
        check("a_busy_start", 32'(busy_a), 32'h1);
        repeat (3) tick();
        check("a_ack_early", 32'(ack_a), 32'h0);
        tick();
        check("a_ack_pulse", 32'(ack_a), 32'(oh));
        check("a_busy_ack", 32'(busy_a), 32'h1);
        tick();
        check("a_ack_end", 32'(ack_a), 32'h0);
        check("a_busy_end", 32'(busy_a), 32'h0);
        check("a_is0_hold", 32'(is0_a), 32'(is0_after));
    endtask

    task automatic run_seq_b(input int idx, input logic [4:0] is0_after);
        logic [4:0] oh;
        exp_t e;
        oh    = 5'b00001 << idx;
        e.ack = oh;
        e.is0 = is0_after;
        qb.push_back(e);
        tick();
        check("b_is0_change", 32'(is0_b), 32'(is0_after));
        check("b_cur_idx", 32'(cur_b), 32'(idx));
        check("b_busy_start", 32'(busy_b), 32'h1);
        check("b_ack_early", 32'(ack_b), 32'h0);
        tick();
        check("b_ack_pulse", 32'(ack_b), 32'(oh));
        check("b_busy_ack", 32'(busy_b), 32'h1);
        tick();
        check("b_ack_end", 32'(ack_b), 32'h0);
        check("b_busy_end", 32'(busy_b), 32'h0);
    endtask

    initial begin
        RST_N = 1'b0;
        req_a = 5'b11111;
        req_b = 5'b00000;
        repeat (3) tick();
        check("rst_is0", 32'(is0_a), 32'h0);
        check("rst_ack", 32'(ack_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_cur", 32'(cur_a), 32'h0);

        // First change after release must be channel 0.
        RST_N = 1'b1;
        tick();
        check("first_is0", 32'(is0_a), 32'h01);
        check("first_cur", 32'(cur_a), 32'h0);
        check("first_busy", 32'(busy_a), 32'h1);

        // Asynchronous reset in the middle of SETTLE, away from any edge.
        tick();
        #3;
        RST_N = 1'b0;
        #1;
        check("arst_is0", 32'(is0_a), 32'h0);
        check("arst_busy", 32'(busy_a), 32'h0);
        check("arst_ack", 32'(ack_a), 32'h0);
        req_a = 5'b00000;
        tick();
        tick();
        RST_N = 1'b1;
        repeat (8) tick();
        check("arst_no_resume_is0", 32'(is0_a), 32'h0);
        check("arst_no_resume_busy", 32'(busy_a), 32'h0);

        // Single enable; pointer ends at 3.
        req_a = 5'b00100;
        run_seq_a(2, 5'b00100);
        // Clearing it leaves IS0=0 with the pointer still at 3.
        req_a = 5'b00000;
        run_seq_a(2, 5'b00000);

        // Round-robin from pointer 3: order 3, 0, 1, six cycles apart.
        req_a = 5'b01011;
        run_seq_a(3, 5'b01000);
        run_seq_a(0, 5'b01001);
        run_seq_a(1, 5'b01011);
        // Pointer now 2: clearing walks 3, 0, 1.
        req_a = 5'b00000;
        run_seq_a(3, 5'b00011);
        run_seq_a(0, 5'b00010);
        run_seq_a(1, 5'b00000);

        // Reversal: raise REQ_EN[1], drop it two cycles later.
        req_a = 5'b00010;
        begin
            exp_t e;
            e.ack = 5'b00010;
            e.is0 = 5'b00010;
            qa.push_back(e);
        end
        tick();
        check("rev_is0_rise", 32'(is0_a), 32'h02);
        tick();
        tick();
        req_a = 5'b00000;
        tick();
        check("rev_is0_frozen", 32'(is0_a), 32'h02);
        tick();
        check("rev_ack1", 32'(ack_a), 32'h02);
        tick();
        check("rev_busy_drop", 32'(busy_a), 32'h0);
        run_seq_a(1, 5'b00000);

        // Matching request: nothing starts.
        repeat (4) tick();
        check("noop_busy", 32'(busy_a), 32'h0);
        check("noop_is0", 32'(is0_a), 32'h0);

        // SETTLE_CYCLES=1 build, including pointer wrap from channel 4 to 0.
        req_b = 5'b10000;
        run_seq_b(4, 5'b10000);
        req_b = 5'b10011;
        run_seq_b(0, 5'b10001);
        run_seq_b(1, 5'b10011);

        repeat (4) tick();
        check("a_queue_empty", 32'(qa.size()), 32'h0);
        check("b_queue_empty", 32'(qb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
